// File: rtl/axi_ddr_responder.sv
// +--------------------------------------------------------------------------+
// | axi_ddr_responder : AXI4 INCR-burst slave memory model (DDR stand-in).     |
// | Optional: define AXI_DDR_RESP_ERR_EN for SLVERR on out-of-range/wlast err. |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module axi_ddr_responder #(
  parameter int                    AXI_ADDR_W   = 64,
  parameter int                    AXI_DATA_W   = 128,
  parameter int                    AXI_ID_W     = 4,
  parameter int                    MEM_AW       = 12,
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR    = 64'h0000_0000_1000_0000,
  parameter int                    READ_LATENCY = 4
) (
  input  logic                    clk_pl,
  input  logic                    rstn_pl,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [AXI_ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [AXI_ID_W-1:0]     s_axi_arid,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [AXI_DATA_W-1:0]   s_axi_rdata,
  output logic [AXI_ID_W-1:0]     s_axi_rid,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [AXI_ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [AXI_ID_W-1:0]     s_axi_awid,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  input  logic [AXI_DATA_W-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_W/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [AXI_ID_W-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp
);

`ifdef AXI_DDR_RESP_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  localparam int STRB_W = AXI_DATA_W / 8;
  localparam int LOG2B  = $clog2(STRB_W);
  localparam int DEPTH  = 1 << MEM_AW;
  localparam int CNT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} rstate_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_e;

  logic [AXI_DATA_W-1:0] mem_q [DEPTH];

  // Address decode: oob marks a start word outside the array (or below base).
  logic [AXI_ADDR_W-1:0] ar_word, aw_word;
  logic [MEM_AW-1:0]     ar_idx, aw_idx;
  logic                  ar_oob, aw_oob;

  assign ar_word = (s_axi_araddr - BASE_ADDR) >> LOG2B;
  assign aw_word = (s_axi_awaddr - BASE_ADDR) >> LOG2B;
  assign ar_idx  = ar_word[MEM_AW-1:0];
  assign aw_idx  = aw_word[MEM_AW-1:0];
  assign ar_oob  = (s_axi_araddr < BASE_ADDR) || (|ar_word[AXI_ADDR_W-1:MEM_AW]);
  assign aw_oob  = (s_axi_awaddr < BASE_ADDR) || (|aw_word[AXI_ADDR_W-1:MEM_AW]);

  // ---------------- read engine ----------------
  rstate_e           rstate_q, rstate_d;
  logic [MEM_AW-1:0] ridx_q, ridx_d, r_fetch_idx;
  logic              roob_q, roob_d, r_fetch_oob, r_load;
  logic [7:0]        rlen_q, rlen_d, rbeat_q, rbeat_d;
  logic [AXI_ID_W-1:0] rid_q, rid_d;
  logic [CNT_W-1:0]  rcnt_q, rcnt_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [AXI_DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;

  always_comb begin
    rstate_d    = rstate_q;
    ridx_d      = ridx_q;
    roob_d      = roob_q;
    rlen_d      = rlen_q;
    rbeat_d     = rbeat_q;
    rid_d       = rid_q;
    rcnt_d      = rcnt_q;
    r_load      = 1'b0;
    r_fetch_idx = ridx_q;
    r_fetch_oob = roob_q;
    case (rstate_q)
      R_IDLE: begin
        if (s_axi_arvalid && arready_q) begin
          ridx_d   = ar_idx;
          roob_d   = ar_oob;
          rlen_d   = s_axi_arlen;
          rbeat_d  = 8'd0;
          rid_d    = s_axi_arid;
          rcnt_d   = CNT_W'(READ_LATENCY - 1);
          rstate_d = R_WAIT;
        end
      end
      R_WAIT: begin
        // Counter loaded with latency-1 so the fetch edge is latency edges after AR.
        if (rcnt_q == '0) begin
          r_load   = 1'b1;
          rstate_d = R_DATA;
        end else begin
          rcnt_d = rcnt_q - CNT_W'(1);
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          if (rbeat_q == rlen_q) begin
            rstate_d = R_IDLE;
          end else begin
            ridx_d      = ridx_q + MEM_AW'(1);
            roob_d      = roob_q | (&ridx_q);
            rbeat_d     = rbeat_q + 8'd1;
            r_load      = 1'b1;
            r_fetch_idx = ridx_d;
            r_fetch_oob = roob_d;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    arready_d = (rstate_d == R_IDLE);
    rvalid_d  = (rstate_d == R_DATA);
    rlast_d   = (rstate_d == R_DATA) && (rbeat_d == rlen_d);
  end

  always_ff @(posedge clk_pl) begin
    if (!rstn_pl) begin
      rstate_q  <= R_IDLE;
      ridx_q    <= '0;
      roob_q    <= 1'b0;
      rlen_q    <= '0;
      rbeat_q   <= '0;
      rid_q     <= '0;
      rcnt_q    <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      rstate_q  <= rstate_d;
      ridx_q    <= ridx_d;
      roob_q    <= roob_d;
      rlen_q    <= rlen_d;
      rbeat_q   <= rbeat_d;
      rid_q     <= rid_d;
      rcnt_q    <= rcnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      if (r_load) begin
        rdata_q <= mem_q[r_fetch_idx];
        rresp_q <= {ERR_EN & r_fetch_oob, 1'b0};
      end
    end
  end

  // ---------------- write engine ----------------
  wstate_e           wstate_q, wstate_d;
  logic [MEM_AW-1:0] widx_q, widx_d;
  logic              woob_q, woob_d, werr_q, werr_d, mem_we;
  logic [7:0]        wlen_q, wlen_d, wbeat_q, wbeat_d;
  logic [AXI_ID_W-1:0] wid_q, wid_d;
  logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;

  always_comb begin
    wstate_d = wstate_q;
    widx_d   = widx_q;
    woob_d   = woob_q;
    werr_d   = werr_q;
    wlen_d   = wlen_q;
    wbeat_d  = wbeat_q;
    wid_d    = wid_q;
    bresp_d  = bresp_q;
    mem_we   = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (s_axi_awvalid && awready_q) begin
          widx_d   = aw_idx;
          woob_d   = aw_oob;
          werr_d   = 1'b0;
          wlen_d   = s_axi_awlen;
          wbeat_d  = 8'd0;
          wid_d    = s_axi_awid;
          wstate_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid && wready_q) begin
          mem_we = rstn_pl && !(ERR_EN && woob_q);
          werr_d = werr_q | (ERR_EN & (woob_q | (s_axi_wlast != (wbeat_q == wlen_q))));
          if (wbeat_q == wlen_q) begin
            bresp_d  = {werr_d, 1'b0};
            wstate_d = W_RESP;
          end else begin
            widx_d  = widx_q + MEM_AW'(1);
            woob_d  = woob_q | (&widx_q);
            wbeat_d = wbeat_q + 8'd1;
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
    awready_d = (wstate_d == W_IDLE);
    wready_d  = (wstate_d == W_DATA);
    bvalid_d  = (wstate_d == W_RESP);
  end

  always_ff @(posedge clk_pl) begin
    if (!rstn_pl) begin
      wstate_q  <= W_IDLE;
      widx_q    <= '0;
      woob_q    <= 1'b0;
      werr_q    <= 1'b0;
      wlen_q    <= '0;
      wbeat_q   <= '0;
      wid_q     <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      wstate_q  <= wstate_d;
      widx_q    <= widx_d;
      woob_q    <= woob_d;
      werr_q    <= werr_d;
      wlen_q    <= wlen_d;
      wbeat_q   <= wbeat_d;
      wid_q     <= wid_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Storage is deliberately never reset; a read in the same cycle sees old data.
  always_ff @(posedge clk_pl) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (mem_we && s_axi_wstrb[b]) mem_q[widx_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = wid_q;
  assign s_axi_bresp   = bresp_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_ddr_responder.sv
// +--------------------------------------------------------------------------+
// | tb_axi_ddr_responder : directed self-checking bench for axi_ddr_responder. |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_axi_ddr_responder;

  localparam logic [63:0] BASE = 64'h0000_0000_1000_0000;
  localparam int          LAT  = 4;

  logic         clk_pl = 1'b0;
  logic         rstn_pl;
  logic         s_axi_arvalid, s_axi_arready;
  logic [63:0]  s_axi_araddr;
  logic [7:0]   s_axi_arlen;
  logic [3:0]   s_axi_arid;
  logic         s_axi_rvalid, s_axi_rready;
  logic [127:0] s_axi_rdata;
  logic [3:0]   s_axi_rid;
  logic [1:0]   s_axi_rresp;
  logic         s_axi_rlast;
  logic         s_axi_awvalid, s_axi_awready;
  logic [63:0]  s_axi_awaddr;
  logic [7:0]   s_axi_awlen;
  logic [3:0]   s_axi_awid;
  logic         s_axi_wvalid, s_axi_wready;
  logic [127:0] s_axi_wdata;
  logic [15:0]  s_axi_wstrb;
  logic         s_axi_wlast;
  logic         s_axi_bvalid, s_axi_bready;
  logic [3:0]   s_axi_bid;
  logic [1:0]   s_axi_bresp;

  int n_checks = 0;
  int n_errors = 0;
  logic [127:0] wbuf [16];
  logic [127:0] ebuf [16];

  axi_ddr_responder dut (
    .clk_pl(clk_pl), .rstn_pl(rstn_pl),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arid(s_axi_arid),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rid(s_axi_rid),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awid(s_axi_awid),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp)
  );

  always #5 clk_pl = ~clk_pl;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pl);
    #1;
  endtask

  task automatic axi_write(input logic [63:0] addr, input logic [7:0] len,
                           input logic [3:0] id, input logic [15:0] strb);
    int t;
    s_axi_awvalid = 1'b1; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awid = id;
    t = 0;
    while (!s_axi_awready && t < 50) begin tick(); t++; end
    check("awready", s_axi_awready, 1'b1);
    tick();
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      s_axi_wvalid = 1'b1; s_axi_wdata = wbuf[i]; s_axi_wstrb = strb;
      s_axi_wlast = (i == int'(len));
      t = 0;
      while (!s_axi_wready && t < 50) begin tick(); t++; end
      tick();
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    check("bvalid", s_axi_bvalid, 1'b1);
    check("bresp", s_axi_bresp, 2'b00);
    check("bid", s_axi_bid, id);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    check("bvalid_clr", s_axi_bvalid, 1'b0);
  endtask

  // pat supplies rready per cycle (bit k%4) while the data phase is running.
  task automatic axi_read(input logic [63:0] addr, input logic [7:0] len, input logic [3:0] id,
                          input logic [1:0] resp, input logic [3:0] pat);
    int t;
    int beat;
    int k;
    s_axi_arvalid = 1'b1; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arid = id;
    t = 0;
    while (!s_axi_arready && t < 50) begin tick(); t++; end
    check("arready", s_axi_arready, 1'b1);
    tick();
    s_axi_arvalid = 1'b0;
    t = 0;
    while (!s_axi_rvalid && t < 50) begin tick(); t++; end
    check("rd_latency", t, LAT);
    beat = 0; k = 0;
    while (beat <= int'(len) && k < 400) begin
      s_axi_rready = pat[k % 4];
      check("rvalid_held", s_axi_rvalid, 1'b1);
      if (s_axi_rvalid) begin
        check("rdata", s_axi_rdata, ebuf[beat]);
        check("rlast", s_axi_rlast, beat == int'(len));
        check("rresp", s_axi_rresp, resp);
        check("rid", s_axi_rid, id);
        if (s_axi_rready) beat++;
      end
      tick();
      k++;
    end
    s_axi_rready = 1'b0;
    check("rd_beats", beat, int'(len) + 1);
    check("rvalid_end", s_axi_rvalid, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rstn_pl = 1'b0;
    s_axi_arvalid = 0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arid = '0; s_axi_rready = 0;
    s_axi_awvalid = 0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awid = '0;
    s_axi_wvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 0; s_axi_bready = 0;
    repeat (3) tick();
    check("rst_arready", s_axi_arready, 1'b0);
    check("rst_awready", s_axi_awready, 1'b0);
    check("rst_wready", s_axi_wready, 1'b0);
    check("rst_rvalid", s_axi_rvalid, 1'b0);
    check("rst_bvalid", s_axi_bvalid, 1'b0);
    check("rst_rlast", s_axi_rlast, 1'b0);
    check("rst_rdata", s_axi_rdata, 128'd0);
    check("rst_resp", {s_axi_rresp, s_axi_bresp, s_axi_rid, s_axi_bid}, 12'd0);
    rstn_pl = 1'b1;
    tick();
    check("rel_arready", s_axi_arready, 1'b1);
    check("rel_awready", s_axi_awready, 1'b1);

    // Basic 4-beat write then read back at BASE.
    for (int i = 0; i < 4; i++) begin wbuf[i] = 128'(i + 1); ebuf[i] = 128'(i + 1); end
    axi_write(BASE, 8'd3, 4'd5, 16'hFFFF);
    axi_read(BASE, 8'd3, 4'd9, 2'b00, 4'b1111);

    // Backpressure on R: rready 1,0,0,1 repeating.
    axi_read(BASE, 8'd3, 4'd2, 2'b00, 4'b1001);

    // Partial strobe: only byte 0 overwritten with zero.
    wbuf[0] = {128{1'b1}};
    axi_write(BASE + 64'h320, 8'd0, 4'd1, 16'hFFFF);
    wbuf[0] = 128'd0;
    axi_write(BASE + 64'h320, 8'd0, 4'd1, 16'h0001);
    ebuf[0] = {{15{8'hFF}}, 8'h00};
    axi_read(BASE + 64'h320, 8'd0, 4'd3, 2'b00, 4'b1111);

    // Concurrent 16-beat read of A (words 0..15) and write of D (words 100..115).
    for (int i = 0; i < 16; i++) wbuf[i] = 128'h0A00_0000 + 128'(i);
    axi_write(BASE, 8'd15, 4'd4, 16'hFFFF);
    for (int i = 0; i < 16; i++) begin
      ebuf[i] = 128'h0A00_0000 + 128'(i);
      wbuf[i] = 128'h0D00_0000 + 128'(i);
    end
    fork
      axi_read(BASE, 8'd15, 4'd6, 2'b00, 4'b1111);
      axi_write(BASE + 64'h640, 8'd15, 4'd7, 16'hFFFF);
    join
    for (int i = 0; i < 16; i++) ebuf[i] = 128'h0D00_0000 + 128'(i);
    axi_read(BASE + 64'h640, 8'd15, 4'd8, 2'b00, 4'b1111);

    // Same-word collision on word 200: fetch edge coincides with the write edge.
    wbuf[0] = 128'h0000_0000_0000_0000_0000_0000_0000_0DD0;
    axi_write(BASE + 64'hC80, 8'd0, 4'd1, 16'hFFFF);
    s_axi_awvalid = 1'b1; s_axi_awaddr = BASE + 64'hC80; s_axi_awlen = 8'd0; s_axi_awid = 4'd2;
    s_axi_arvalid = 1'b1; s_axi_araddr = BASE + 64'hC80; s_axi_arlen = 8'd0; s_axi_arid = 4'd3;
    tick();
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    repeat (LAT - 1) tick();
    s_axi_wvalid = 1'b1; s_axi_wdata = 128'h0000_0000_0000_0000_0000_0000_0000_0EE0;
    s_axi_wstrb = 16'hFFFF; s_axi_wlast = 1'b1;
    tick();
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    check("coll_rvalid", s_axi_rvalid, 1'b1);
    check("coll_old", s_axi_rdata, 128'h0DD0);
    check("coll_bvalid", s_axi_bvalid, 1'b1);
    s_axi_rready = 1'b1; s_axi_bready = 1'b1;
    tick();
    s_axi_rready = 1'b0; s_axi_bready = 1'b0;
    ebuf[0] = 128'h0EE0;
    axi_read(BASE + 64'hC80, 8'd0, 4'd3, 2'b00, 4'b1111);

    // Reset while beat 2 of an 8-beat read of A is presented.
    for (int i = 0; i < 8; i++) ebuf[i] = 128'h0A00_0000 + 128'(i);
    s_axi_arvalid = 1'b1; s_axi_araddr = BASE; s_axi_arlen = 8'd7; s_axi_arid = 4'd5;
    tick();
    s_axi_arvalid = 1'b0;
    repeat (LAT) tick();
    check("mid_rvalid", s_axi_rvalid, 1'b1);
    s_axi_rready = 1'b1;
    repeat (2) tick();
    check("mid_beat2", s_axi_rdata, ebuf[2]);
    rstn_pl = 1'b0;
    tick();
    s_axi_rready = 1'b0;
    check("mid_rst_rvalid", s_axi_rvalid, 1'b0);
    check("mid_rst_arready", s_axi_arready, 1'b0);
    rstn_pl = 1'b1;
    tick();
    check("mid_rel_arready", s_axi_arready, 1'b1);
    axi_read(BASE, 8'd7, 4'd5, 2'b00, 4'b1111);

    // Address below base: wraps to word 4095 (or SLVERR when error reporting is built in).
    wbuf[0] = 128'h0000_0000_0000_0000_0000_0000_0000_BEEF;
    axi_write(BASE + 64'hFFF0, 8'd0, 4'd1, 16'hFFFF);
    ebuf[0] = 128'hBEEF;
`ifdef AXI_DDR_RESP_ERR_EN
    axi_read(BASE - 64'd16, 8'd0, 4'd2, 2'b10, 4'b1111);
`else
    axi_read(BASE - 64'd16, 8'd0, 4'd2, 2'b00, 4'b1111);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
